// File: rtl/trace_line_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_line_sequencer_if
// Purpose  : Bundles the requester snapshot inputs and the character output
//            channel of trace_line_sequencer. The sequencer uses the master
//            view; the environment driving requesters and sinking characters
//            uses the slave view.
// Revision : 1.0 - initial release
// ============================================================================
interface trace_line_sequencer_if #(
    parameter int P_NREQS  = 4,
    parameter int P_NCHARS = 8
) ();
    logic                          start;
    logic [P_NREQS-1:0]            req_val;
    logic [P_NREQS-1:0]            req_rdy;
    logic [P_NREQS*P_NCHARS*8-1:0] req_str;
    logic                          out_val;
    logic                          out_rdy;
    logic [7:0]                    out_char;
    logic                          busy;
    logic [31:0]                   cycles;
    logic [15:0]                   drop_count;

    modport master (
        input  start, req_val, req_rdy, req_str, out_rdy,
        output out_val, out_char, busy, cycles, drop_count
    );

    modport slave (
        output start, req_val, req_rdy, req_str, out_rdy,
        input  out_val, out_char, busy, cycles, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/trace_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trace_line_sequencer
// Purpose  : Snapshots P_NREQS requesters (val/rdy/string) on start and emits
//            one formatted text line, one character per out_val/out_rdy
//            handshake: fields separated by '|', terminated by '\n'.
// Options  : TRACE_LINE_SEQ_CYCLE_EN - prefix each line with a 4-digit BCD
//            cycle stamp followed by ": ".
// Revision : 1.0 - initial release
// ============================================================================
module trace_line_sequencer #(
    parameter int P_NREQS  = 4,
    parameter int P_NCHARS = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    trace_line_sequencer_if.master  bus
);

    localparam int REQ_W = (P_NREQS  > 1) ? $clog2(P_NREQS)  : 1;
    localparam int CHR_W = (P_NCHARS > 1) ? $clog2(P_NCHARS) : 1;
    localparam int STR_W = P_NREQS * P_NCHARS * 8;

    localparam logic [REQ_W-1:0] c_last_req = REQ_W'(P_NREQS - 1);
    localparam logic [CHR_W-1:0] c_last_chr = CHR_W'(P_NCHARS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIELD = 3'd1,
        S_SEP   = 3'd2,
        S_NL    = 3'd3
`ifdef TRACE_LINE_SEQ_CYCLE_EN
        ,
        S_PFX   = 3'd4
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    state_t             w_first_state;
    logic [REQ_W-1:0]   r_req_idx;
    logic [CHR_W-1:0]   r_chr_idx;
    logic [P_NREQS-1:0] r_snap_val;
    logic [P_NREQS-1:0] r_snap_rdy;
    logic [STR_W-1:0]   r_snap_str;
    logic               r_out_val;
    logic [31:0]        r_cycles;
    logic [15:0]        r_drops;
    logic [7:0]         w_out_char;
    logic               w_hs;
    logic               w_accept;
    logic               w_last_chr;
    logic               w_last_req;
    logic [7:0]         w_cur_chr;
    logic               w_cur_val;
    logic               w_cur_rdy;

    // Snapshot characters unpacked so char 0 (leftmost) sits at index 0.
    logic [7:0] w_chars [P_NREQS][P_NCHARS];

    for (genvar i = 0; i < P_NREQS; i++) begin : g_req
        for (genvar k = 0; k < P_NCHARS; k++) begin : g_chr
            assign w_chars[i][k] = r_snap_str[i*P_NCHARS*8 + (P_NCHARS-1-k)*8 +: 8];
        end
    end

    assign w_hs       = r_out_val & bus.out_rdy;
    // A new line may start from idle, or from the newline slot when the
    // newline is leaving this very cycle (back-to-back lines, no bubble).
    assign w_accept   = bus.start & ((r_state == S_IDLE) |
                                     ((r_state == S_NL) & bus.out_rdy));
    assign w_last_chr = (r_chr_idx == c_last_chr);
    assign w_last_req = (r_req_idx == c_last_req);
    assign w_cur_chr  = w_chars[r_req_idx][r_chr_idx];
    assign w_cur_val  = r_snap_val[r_req_idx];
    assign w_cur_rdy  = r_snap_rdy[r_req_idx];

`ifdef TRACE_LINE_SEQ_CYCLE_EN
    assign w_first_state = S_PFX;

    logic [15:0] r_bcd;
    logic [15:0] r_snap_bcd;
    logic [15:0] w_bcd_next;
    logic [2:0]  r_pfx_idx;

    // Four-digit decimal ripple increment, 9999 wraps to 0000.
    always_comb begin
        logic carry;
        w_bcd_next = r_bcd;
        carry      = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r_bcd[d*4 +: 4] == 4'd9) begin
                    w_bcd_next[d*4 +: 4] = 4'd0;
                end else begin
                    w_bcd_next[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

    // BCD stamp counter, its per-line snapshot and the prefix position.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd      <= 16'h0000;
            r_snap_bcd <= 16'h0000;
            r_pfx_idx  <= 3'd0;
        end else begin
            r_bcd <= w_bcd_next;
            if (w_accept) begin
                r_snap_bcd <= r_bcd;
                r_pfx_idx  <= 3'd0;
            end else if ((r_state == S_PFX) && w_hs) begin
                r_pfx_idx <= r_pfx_idx + 3'd1;
            end
        end
    end
`else
    assign w_first_state = S_FIELD;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and rendering of the character currently offered.
    always_comb begin
        w_next_state = r_state;
        w_out_char   = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_first_state;
                end
            end
`ifdef TRACE_LINE_SEQ_CYCLE_EN
            S_PFX: begin
                case (r_pfx_idx)
                    3'd0:    w_out_char = {4'h3, r_snap_bcd[15:12]};
                    3'd1:    w_out_char = {4'h3, r_snap_bcd[11:8]};
                    3'd2:    w_out_char = {4'h3, r_snap_bcd[7:4]};
                    3'd3:    w_out_char = {4'h3, r_snap_bcd[3:0]};
                    3'd4:    w_out_char = 8'h3A;
                    default: w_out_char = 8'h20;
                endcase
                if (w_hs && (r_pfx_idx == 3'd5)) begin
                    w_next_state = S_FIELD;
                end
            end
`endif
            S_FIELD: begin
                case ({w_cur_val, w_cur_rdy})
                    2'b11:   w_out_char = (w_cur_chr == 8'h00) ? 8'h20 : w_cur_chr;
                    2'b01:   w_out_char = 8'h20;
                    2'b10:   w_out_char = (r_chr_idx == '0) ? 8'h23 : 8'h20;
                    default: w_out_char = (r_chr_idx == '0) ? 8'h2E : 8'h20;
                endcase
                if (w_hs && w_last_chr) begin
                    w_next_state = w_last_req ? S_NL : S_SEP;
                end
            end
            S_SEP: begin
                w_out_char = 8'h7C;
                if (w_hs) begin
                    w_next_state = S_FIELD;
                end
            end
            S_NL: begin
                w_out_char = 8'h0A;
                if (w_accept) begin
                    w_next_state = w_first_state;
                end else if (w_hs) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Line buffer capture and field/character position tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_idx  <= '0;
            r_chr_idx  <= '0;
            r_snap_val <= '0;
            r_snap_rdy <= '0;
            r_snap_str <= '0;
        end else if (w_accept) begin
            r_req_idx  <= '0;
            r_chr_idx  <= '0;
            r_snap_val <= bus.req_val;
            r_snap_rdy <= bus.req_rdy;
            r_snap_str <= bus.req_str;
        end else if (w_hs) begin
            if (r_state == S_FIELD) begin
                r_chr_idx <= w_last_chr ? '0 : (r_chr_idx + CHR_W'(1));
            end else if (r_state == S_SEP) begin
                r_req_idx <= r_req_idx + REQ_W'(1);
            end
        end
    end

    // Output valid is registered from the next state, so out_rdy never
    // reaches out_val combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_val <= 1'b0;
        end else begin
            r_out_val <= (w_next_state != S_IDLE);
        end
    end

    // Free-running cycle counter and saturating count of discarded starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycles <= 32'd0;
            r_drops  <= 16'd0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (bus.start && !w_accept && (r_drops != 16'hFFFF)) begin
                r_drops <= r_drops + 16'd1;
            end
        end
    end

    assign bus.out_val    = r_out_val;
    assign bus.out_char   = w_out_char;
    assign bus.busy       = r_out_val;
    assign bus.cycles     = r_cycles;
    assign bus.drop_count = r_drops;

endmodule
`default_nettype wire
